pipe_ctrl: RTL and testbench

Central stall/flush controller for the five-stage core. It drives the 2-bit stall code of the PC register and of every pipeline register: if_id, id_ex, ex_mem and mem_wb. It resolves hazards and flushes from the IF, ID, EX and MEM stages in a fixed priority order. It also sequences multi-cycle MUL/DIV occupancy of EX and discards wrong-path fetches that are still in flight when a redirect occurs.

---
 rtl/pipe_ctrl.sv | 126 ++++++++++++
 tb/tb_pipe_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - central stall/flush controller for the five-stage core
module pipe_ctrl #(
    parameter int MDU_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_busy,
    input  logic        mem_busy,
    input  logic        ld_use,
    input  logic        ex_redirect,
    input  logic        ex_mdu_start,
    output logic [1:0]  stall_pc,
    output logic [1:0]  stall_if_id,
    output logic [1:0]  stall_id_ex,
    output logic [1:0]  stall_ex_mem,
    output logic [1:0]  stall_mem_wb,
    output logic        if_drop,
    output logic        mdu_done,
    output logic [63:0] stall_count
);

    localparam int CNT_W = $clog2(MDU_CYCLES);

    localparam logic [1:0] NEXT = 2'b00;
    localparam logic [1:0] KEEP = 2'b01;
    localparam logic [1:0] ZERO = 2'b10;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]       mstate_q, mstate_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             drop_pending_q, drop_pending_d;
    logic [63:0]      stall_count_q, stall_count_d;
    logic             mdu_stall;

    always_comb begin
        mstate_d       = mstate_q;
        cnt_d          = cnt_q;
        drop_pending_d = drop_pending_q;
        stall_pc       = NEXT;
        stall_if_id    = NEXT;
        stall_id_ex    = NEXT;
        stall_ex_mem   = NEXT;
        stall_mem_wb   = NEXT;
        if_drop        = 1'b0;
        mdu_done       = 1'b0;

        mdu_stall = ((mstate_q == IDLE) && ex_mdu_start) ||
                    ((mstate_q == BUSY) && (cnt_q != '0));

        // The MDU sequencer is frozen for the whole duration of a MEM stall.
        if (!mem_busy) begin
            if (mstate_q == IDLE) begin
                if (ex_mdu_start) begin
                    mstate_d = BUSY;
                    cnt_d    = CNT_W'(MDU_CYCLES - 2);
                end
            end else if (cnt_q != '0) begin
                cnt_d = cnt_q - CNT_W'(1);
            end else begin
                mstate_d = IDLE;
                mdu_done = 1'b1;
            end
        end

        if (mem_busy) begin
            stall_pc     = KEEP;
            stall_if_id  = KEEP;
            stall_id_ex  = KEEP;
            stall_ex_mem = KEEP;
            stall_mem_wb = ZERO;
        end else if (mdu_stall) begin
            stall_pc     = KEEP;
            stall_if_id  = KEEP;
            stall_id_ex  = KEEP;
            stall_ex_mem = ZERO;
        end else if (ex_redirect) begin
            stall_if_id    = ZERO;
            stall_id_ex    = ZERO;
            drop_pending_d = drop_pending_q | if_busy;
        end else if (drop_pending_q && !if_busy) begin
            // Stale wrong-path fetch lands now: discard it and hold the new PC.
            if_drop        = 1'b1;
            stall_pc       = KEEP;
            stall_if_id    = ZERO;
            drop_pending_d = 1'b0;
        end else if (ld_use) begin
            stall_pc    = KEEP;
            stall_if_id = (drop_pending_q && if_busy) ? ZERO : KEEP;
            stall_id_ex = ZERO;
        end else if (if_busy) begin
            stall_pc    = KEEP;
            stall_if_id = ZERO;
        end

        stall_count_d = stall_count_q + {63'd0, (stall_pc != NEXT)};

        if (rst) begin
            stall_pc     = ZERO;
            stall_if_id  = ZERO;
            stall_id_ex  = ZERO;
            stall_ex_mem = ZERO;
            stall_mem_wb = ZERO;
            if_drop      = 1'b0;
            mdu_done     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mstate_q       <= IDLE;
            cnt_q          <= '0;
            drop_pending_q <= 1'b0;
            stall_count_q  <= 64'd0;
        end else begin
            mstate_q       <= mstate_d;
            cnt_q          <= cnt_d;
            drop_pending_q <= drop_pending_d;
            stall_count_q  <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - randomized and directed self-checking bench for pipe_ctrl
module tb_pipe_ctrl;

    localparam int MDU = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_busy = 1'b1, mem_busy = 1'b1, ld_use = 1'b1;
    logic        ex_redirect = 1'b1, ex_mdu_start = 1'b1;
    logic [1:0]  stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb;
    logic        if_drop, mdu_done;
    logic [63:0] stall_count;

    int errors = 0;
    int checks = 0;

    // Reference state: remaining EX occupancy cycles (0 = no MUL/DIV), drop flag, stall total.
    int              m_left  = 0;
    bit              m_drop  = 0;
    longint unsigned m_count = 0;

    logic [1:0] e_pc, e_ifid, e_idex, e_exmem, e_memwb;
    logic       e_drop, e_done;
    int         e_rule;

    pipe_ctrl #(.MDU_CYCLES(MDU)) dut (
        .clk(clk), .rst(rst), .if_busy(if_busy), .mem_busy(mem_busy),
        .ld_use(ld_use), .ex_redirect(ex_redirect), .ex_mdu_start(ex_mdu_start),
        .stall_pc(stall_pc), .stall_if_id(stall_if_id), .stall_id_ex(stall_id_ex),
        .stall_ex_mem(stall_ex_mem), .stall_mem_wb(stall_mem_wb),
        .if_drop(if_drop), .mdu_done(mdu_done), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_eval();
        bit stall_mdu;
        {e_pc, e_ifid, e_idex, e_exmem, e_memwb} = 10'b0;
        e_drop = 0;
        e_done = 0;
        e_rule = 7;
        if (rst) begin
            {e_pc, e_ifid, e_idex, e_exmem, e_memwb} = {5{2'b10}};
            e_rule = 0;
            return;
        end
        stall_mdu = (m_left == 0 && ex_mdu_start) || (m_left > 1);
        e_done = (m_left == 1) && !mem_busy;
        if (mem_busy) begin
            {e_pc, e_ifid, e_idex, e_exmem, e_memwb} = {2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
            e_rule = 1;
        end else if (stall_mdu) begin
            {e_pc, e_ifid, e_idex, e_exmem, e_memwb} = {2'b01, 2'b01, 2'b01, 2'b10, 2'b00};
            e_rule = 2;
        end else if (ex_redirect) begin
            {e_pc, e_ifid, e_idex, e_exmem, e_memwb} = {2'b00, 2'b10, 2'b10, 2'b00, 2'b00};
            e_rule = 3;
        end else if (m_drop && !if_busy) begin
            {e_pc, e_ifid, e_idex, e_exmem, e_memwb} = {2'b01, 2'b10, 2'b00, 2'b00, 2'b00};
            e_drop = 1;
            e_rule = 4;
        end else if (ld_use) begin
            {e_pc, e_ifid, e_idex, e_exmem, e_memwb} = {2'b01, (m_drop && if_busy) ? 2'b10 : 2'b01, 2'b10, 2'b00, 2'b00};
            e_rule = 5;
        end else if (if_busy) begin
            {e_pc, e_ifid, e_idex, e_exmem, e_memwb} = {2'b01, 2'b10, 2'b00, 2'b00, 2'b00};
            e_rule = 6;
        end
    endtask

    task automatic model_advance();
        if (rst) begin
            m_left = 0;
            m_drop = 0;
            m_count = 0;
            return;
        end
        if (e_pc != 2'b00) m_count++;
        if (!mem_busy) begin
            if (m_left == 0 && ex_mdu_start) m_left = MDU - 1;
            else if (m_left > 0) m_left--;
        end
        if (e_rule == 3) m_drop = m_drop | if_busy;
        if (e_rule == 4) m_drop = 0;
    endtask

    // One clock: drive inputs on the falling edge, compare mid-cycle, advance model on the rising edge.
    task automatic cycle(input logic r, input logic ib, input logic mb,
                         input logic lu, input logic rd, input logic ms);
        @(negedge clk);
        rst = r; if_busy = ib; mem_busy = mb; ld_use = lu; ex_redirect = rd; ex_mdu_start = ms;
        #1;
        model_eval();
        chk("stall_pc", 64'(stall_pc), 64'(e_pc));
        chk("stall_if_id", 64'(stall_if_id), 64'(e_ifid));
        chk("stall_id_ex", 64'(stall_id_ex), 64'(e_idex));
        chk("stall_ex_mem", 64'(stall_ex_mem), 64'(e_exmem));
        chk("stall_mem_wb", 64'(stall_mem_wb), 64'(e_memwb));
        chk("if_drop", 64'(if_drop), 64'(e_drop));
        chk("mdu_done", 64'(mdu_done), 64'(e_done));
        if (!$isunknown(stall_count) || !rst) chk("stall_count", stall_count, m_count);
        fork
            begin @(posedge clk); model_advance(); end
        join_none
    endtask

    task automatic do_reset();
        cycle(1, 1, 1, 1, 1, 1);
        cycle(1, 1, 1, 1, 1, 1);
    endtask

    initial begin
        // Reset with all inputs high.
        do_reset();
        chk("rst_codes", 64'({stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb}), 64'h2AA);
        chk("rst_if_drop", 64'(if_drop), 64'd0);
        chk("rst_count", stall_count, 64'd0);
        cycle(0, 0, 0, 0, 0, 0);
        chk("idle_codes", 64'({stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb}), 64'd0);

        // MUL/DIV, ex_mdu_start held 4 cycles.
        for (int i = 1; i <= 4; i++) begin
            cycle(0, 0, 0, 0, 0, 1);
            chk("mdu_ex_mem", 64'(stall_ex_mem), (i < 4) ? 64'd2 : 64'd0);
            chk("mdu_done_lit", 64'(mdu_done), (i == 4) ? 64'd1 : 64'd0);
        end
        cycle(0, 0, 0, 0, 0, 0);
        chk("mdu_after", 64'(stall_pc), 64'd0);

        // MUL/DIV extended by two mem_busy cycles.
        for (int i = 1; i <= 6; i++) begin
            cycle(0, 0, (i == 3 || i == 4), 0, 0, 1);
            chk("mdu_mb_wb", 64'(stall_mem_wb), (i == 3 || i == 4) ? 64'd2 : 64'd0);
            chk("mdu_mb_done", 64'(mdu_done), (i == 6) ? 64'd1 : 64'd0);
        end
        cycle(0, 0, 0, 0, 0, 0);

        // Redirect during an outstanding fetch.
        cycle(0, 1, 0, 0, 1, 0);
        chk("redir_if_id", 64'(stall_if_id), 64'd2);
        chk("redir_id_ex", 64'(stall_id_ex), 64'd2);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1, 0, 0, 0, 0);
            chk("redir_wait_drop", 64'(if_drop), 64'd0);
        end
        cycle(0, 0, 0, 0, 0, 0);
        chk("redir_drop", 64'(if_drop), 64'd1);
        chk("redir_drop_pc", 64'(stall_pc), 64'd1);
        cycle(0, 0, 0, 0, 0, 0);
        chk("redir_after", 64'(if_drop), 64'd0);

        // Priority cases.
        cycle(0, 0, 0, 1, 1, 0);
        chk("prio_rd_lu", 64'({stall_pc, stall_if_id, stall_id_ex}), 64'b00_10_10);
        cycle(0, 0, 1, 1, 0, 0);
        chk("prio_mb_lu", 64'({stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb}), 64'b01_01_01_01_10);

        // Stall counting from a fresh reset.
        do_reset();
        for (int i = 0; i < 5; i++) cycle(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        chk("stall_count_8", stall_count, 64'd8);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 199) == 0,
                  $urandom_range(0, 99) < 35,
                  $urandom_range(0, 99) < 15,
                  $urandom_range(0, 99) < 20,
                  $urandom_range(0, 99) < 15,
                  $urandom_range(0, 99) < 10);
        end
        @(posedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
